// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared op-code constants, FSM state encoding and the default
// datapath width for the iterative ALU. The default width follows
// `REG_FILE_WIDTH, falling back to 32 when that macro is not provided.
// Optional divider support is selected by the ALU_ITER_DIV_EN macro.

`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif

package alu_iter_pkg;

    localparam int ALU_ITER_DEF_WIDTH = `REG_FILE_WIDTH;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLT  = 4'd5;
    localparam logic [3:0] ALU_OP_MUL  = 4'd6;
    localparam logic [3:0] ALU_OP_DIVU = 4'd7;
    localparam logic [3:0] ALU_OP_REMU = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // True for the two ops that share the restoring-division datapath.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_comb.sv
// alu_iter_comb: single-cycle result path of the iterative ALU. Produces the
// result and error flag for every op that finishes in one cycle, and flags
// the ops that must go through the multi-cycle shift datapath instead.
// With ALU_ITER_DIV_EN undefined, DIVU/REMU fall through to the illegal path.

module alu_iter_comb
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = ALU_ITER_DEF_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res,
    output logic             err,
    output logic             iter
);

    // Decode the op; illegal codes leave res at zero and raise err.
    always_comb begin
        res  = '0;
        err  = 1'b0;
        iter = 1'b0;
        case (op)
            ALU_OP_ADD: res = x + y;
            ALU_OP_SUB: res = x - y;
            ALU_OP_AND: res = x & y;
            ALU_OP_OR:  res = x | y;
            ALU_OP_XOR: res = x ^ y;
            ALU_OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_OP_MUL: iter = 1'b1;
`ifdef ALU_ITER_DIV_EN
            // Divide-by-zero is resolved here so it never enters the loop.
            ALU_OP_DIVU: begin
                if (y == '0) begin
                    res = '1;
                    err = 1'b1;
                end else begin
                    iter = 1'b1;
                end
            end
            ALU_OP_REMU: begin
                if (y == '0) begin
                    res = x;
                    err = 1'b1;
                end else begin
                    iter = 1'b1;
                end
            end
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: iterative ALU. Single-cycle ops complete one cycle after
// acceptance; MUL (shift-add) and, when ALU_ITER_DIV_EN is defined,
// DIVU/REMU (restoring shift-subtract) take WIDTH cycles, one bit per cycle.
// The first iteration is performed on the acceptance edge directly from the
// input operands, so WIDTH steps fit in WIDTH cycles of latency.

module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = ALU_ITER_DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] w,
    output logic             zero,
    output logic             err
);

    alu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: partial product / partial remainder
    logic [WIDTH-1:0] acc_q, acc_d;
    // opnd: multiplicand (shifted left) / divisor (constant)
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // shf: multiplier (shifted right) / dividend shifting into quotient
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] c_res;
    logic             c_err;
    logic             c_iter;

    logic [WIDTH-1:0] s_acc, s_opnd, s_shf;
    logic [WIDTH-1:0] mul_acc, mul_opnd, mul_shf;
    logic [WIDTH-1:0] step_acc, step_opnd, step_shf, step_res;

    alu_iter_comb #(.WIDTH(WIDTH)) u_comb (
        .op   (op),
        .x    (x),
        .y    (y),
        .res  (c_res),
        .err  (c_err),
        .iter (c_iter)
    );

    // Step inputs: raw operands on the acceptance edge, registered state in CALC.
    always_comb begin
        if (state_q == ST_IDLE) begin
            s_acc  = '0;
            s_opnd = y;
            s_shf  = x;
        end else begin
            s_acc  = acc_q;
            s_opnd = opnd_q;
            s_shf  = shf_q;
        end
    end

    // One shift-add multiplication step.
    always_comb begin
        mul_acc  = s_acc + (s_shf[0] ? s_opnd : '0);
        mul_opnd = s_opnd << 1;
        mul_shf  = s_shf >> 1;
    end

`ifdef ALU_ITER_DIV_EN
    logic             div_q, div_d;
    logic             rem_q, rem_d;
    logic             sel_div;
    logic [WIDTH:0]   div_part, div_diff;
    logic [WIDTH-1:0] div_acc, div_shf;

    assign sel_div = (state_q == ST_IDLE) ? is_div_op(op) : div_q;

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits (no borrow out of the top bit).
    always_comb begin
        div_part = {s_acc, s_shf[WIDTH-1]};
        div_diff = div_part - {1'b0, s_opnd};
        if (!div_diff[WIDTH]) begin
            div_acc = div_diff[WIDTH-1:0];
            div_shf = {s_shf[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = div_part[WIDTH-1:0];
            div_shf = {s_shf[WIDTH-2:0], 1'b0};
        end
    end

    // Select the active step and the value delivered at the last step.
    always_comb begin
        if (sel_div) begin
            step_acc  = div_acc;
            step_opnd = s_opnd;
            step_shf  = div_shf;
        end else begin
            step_acc  = mul_acc;
            step_opnd = mul_opnd;
            step_shf  = mul_shf;
        end
        if (!div_q) begin
            step_res = mul_acc;
        end else if (rem_q) begin
            step_res = div_acc;
        end else begin
            step_res = div_shf;
        end
    end
`else
    // Multiplier is the only iterative op in this build.
    always_comb begin
        step_acc  = mul_acc;
        step_opnd = mul_opnd;
        step_shf  = mul_shf;
        step_res  = mul_acc;
    end
`endif

    // FSM next state, datapath next values and status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        shf_d   = shf_q;
        w_d     = w_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifdef ALU_ITER_DIV_EN
        div_d   = div_q;
        rem_d   = rem_q;
`endif
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (c_iter) begin
                        state_d = ST_CALC;
                        cnt_d   = CNT_W'(WIDTH);
                        acc_d   = step_acc;
                        opnd_d  = step_opnd;
                        shf_d   = step_shf;
`ifdef ALU_ITER_DIV_EN
                        div_d   = is_div_op(op);
                        rem_d   = (op == ALU_OP_REMU);
`endif
                    end else begin
                        state_d = ST_DONE;
                        w_d     = c_res;
                        zero_d  = (c_res == '0);
                        err_d   = c_err;
                    end
                end
            end
            ST_CALC: begin
                acc_d  = step_acc;
                opnd_d = step_opnd;
                shf_d  = step_shf;
                cnt_d  = cnt_q - CNT_W'(1);
                // Counter reaching 1 marks the final step.
                if (cnt_q == CNT_W'(2)) begin
                    state_d = ST_DONE;
                    w_d     = step_res;
                    zero_d  = (step_res == '0);
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            shf_q   <= '0;
            w_q     <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            div_q   <= 1'b0;
            rem_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            shf_q   <= shf_d;
            w_q     <= w_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
`ifdef ALU_ITER_DIV_EN
            div_q   <= div_d;
            rem_q   <= rem_d;
`endif
        end
    end

    assign w    = w_q;
    assign zero = zero_q;
    assign err  = err_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter at WIDTH=32 and WIDTH=8.
// Expected results are queued when a request is driven and compared when
// done pulses. Divider cases follow ALU_ITER_DIV_EN.

module tb_alu_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        start32, ready32, done32, zero32, err32;
    logic [3:0]  op32;
    logic [31:0] x32, y32, w32;

    logic        start8, ready8, done8, zero8, err8;
    logic [3:0]  op8;
    logic [7:0]  x8, y8, w8;

    alu_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .x(x32), .y(y32),
        .ready(ready32), .done(done32), .w(w32), .zero(zero32), .err(err32)
    );

    alu_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .x(x8), .y(y8),
        .ready(ready8), .done(done8), .w(w8), .zero(zero8), .err(err8)
    );

    typedef struct {
        logic [63:0] w;
        logic        zero;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: one per DUT, compare on every done pulse.
    always @(negedge clk) begin
        if (!reset && done32) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", {63'd0, done32}, 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                $display("txn32 w=%h zero=%b err=%b cyc=%0d", w32, zero32, err32, cyc);
                check("w32", {32'd0, w32}, e.w);
                check("zero32", {63'd0, zero32}, {63'd0, e.zero});
                check("err32", {63'd0, err32}, {63'd0, e.err});
                check("lat32", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", {63'd0, done8}, 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                $display("txn8 w=%h zero=%b err=%b cyc=%0d", w8, zero8, err8, cyc);
                check("w8", {56'd0, w8}, e.w);
                check("zero8", {63'd0, zero8}, {63'd0, e.zero});
                check("err8", {63'd0, err8}, {63'd0, e.err});
                check("lat8", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one request and queue its expected outcome; lat is in cycles.
    task automatic issue(input bit is8, input logic [3:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] ew, input logic eerr,
                         input int lat);
        exp_t e;
        int   guard;
        logic [63:0] mask;
        guard = 0;
        mask  = is8 ? 64'hFF : 64'hFFFF_FFFF;
        @(negedge clk);
        while (!(is8 ? ready8 : ready32) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {63'd0, (is8 ? ready8 : ready32)}, 64'd1);
        e.w    = ew & mask;
        e.zero = (e.w == 64'd0);
        e.err  = eerr;
        e.cyc  = cyc + lat;
        if (is8) begin
            op8 = op; x8 = x[7:0]; y8 = y[7:0]; start8 = 1'b1;
            q8.push_back(e);
        end else begin
            op32 = op; x32 = x[31:0]; y32 = y[31:0]; start32 = 1'b1;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        // Operands changing after acceptance must not matter.
        if (is8) begin
            start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); op8 = 4'($urandom);
        end else begin
            start32 = 1'b0; x32 = $urandom; y32 = $urandom; op32 = 4'($urandom);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        reset = 1'b1;
        start32 = 1'b0; op32 = '0; x32 = '0; y32 = '0;
        start8  = 1'b0; op8  = '0; x8  = '0; y8  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_ready32", {63'd0, ready32}, 64'd1);
        check("rst_done32", {63'd0, done32}, 64'd0);
        check("rst_w32", {32'd0, w32}, 64'd0);
        check("rst_zero32", {63'd0, zero32}, 64'd1);
        check("rst_err32", {63'd0, err32}, 64'd0);
        check("rst_ready8", {63'd0, ready8}, 64'd1);
        check("rst_zero8", {63'd0, zero8}, 64'd1);

        // Single-cycle ops, 32-bit
        issue(0, 4'd0, 64'h1, 64'h1, 64'h2, 1'b0, 1);
        issue(0, 4'd1, 64'hF1, 64'hF1, 64'h0, 1'b0, 1);
        issue(0, 4'd5, 64'hFFFF_FFFF, 64'h1, 64'h1, 1'b0, 1);
        issue(0, 4'd5, 64'h1, 64'hFFFF_FFFF, 64'h0, 1'b0, 1);
        issue(0, 4'd2, 64'hF0F0_1234, 64'h0FF0_FF00, 64'h00F0_1200, 1'b0, 1);
        issue(0, 4'd3, 64'hF000_0001, 64'h0000_0F10, 64'hF000_0F11, 1'b0, 1);
        issue(0, 4'd4, 64'hAAAA_5555, 64'hFFFF_0000, 64'h5555_5555, 1'b0, 1);
        issue(0, 4'd1, 64'h0, 64'h1, 64'hFFFF_FFFF, 1'b0, 1);
        issue(0, 4'hF, 64'h1234, 64'h5678, 64'h0, 1'b1, 1);
        issue(0, 4'd9, 64'h1234, 64'h5678, 64'h0, 1'b1, 1);
        drain(50);

        // MUL with a start pulse mid-operation; ready must stay low
        issue(0, 4'd6, 64'h10, 64'hF1, 64'hF10, 1'b0, 32);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 5) begin start32 = 1'b1; op32 = 4'd0; end
            if (k == 6) start32 = 1'b0;
            if (k < 31) check("busy_ready32", {63'd0, ready32}, 64'd0);
        end
        drain(50);

        // Random MUL operands against a 64-bit product model
        for (int i = 0; i < 3; i++) begin
            a = 64'($urandom);
            b = 64'($urandom);
            issue(0, 4'd6, a, b, a * b, 1'b0, 32);
            drain(50);
        end

`ifdef ALU_ITER_DIV_EN
        issue(0, 4'd7, 64'd100, 64'd7, 64'd14, 1'b0, 32);
        drain(50);
        issue(0, 4'd8, 64'd100, 64'd7, 64'd2, 1'b0, 32);
        drain(50);
        issue(0, 4'd7, 64'd5, 64'd0, 64'hFFFF_FFFF, 1'b1, 1);
        issue(0, 4'd8, 64'd5, 64'd0, 64'd5, 1'b1, 1);
        a = 64'($urandom);
        b = 64'($urandom_range(1, 70000));
        issue(0, 4'd7, a, b, a / b, 1'b0, 32);
        drain(50);
        issue(0, 4'd8, a, b, a % b, 1'b0, 32);
        drain(50);
`else
        issue(0, 4'd7, 64'd100, 64'd7, 64'd0, 1'b1, 1);
        issue(0, 4'd8, 64'd100, 64'd7, 64'd0, 1'b1, 1);
        drain(50);
`endif

        // Reset at cycle 10 of a MUL aborts it without a done pulse
        issue(0, 4'd6, 64'h1234, 64'h5678, 64'h0, 1'b0, 32);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        q32.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready32", {63'd0, ready32}, 64'd1);
        check("abort_w32", {32'd0, w32}, 64'd0);
        check("abort_zero32", {63'd0, zero32}, 64'd1);
        check("abort_done32", {63'd0, done32}, 64'd0);
        repeat (40) @(negedge clk);
        issue(0, 4'd0, 64'd3, 64'd4, 64'd7, 1'b0, 1);
        drain(50);

        // WIDTH=8 instance
        issue(1, 4'd0, 64'h1, 64'h1, 64'h2, 1'b0, 1);
        issue(1, 4'd1, 64'hF1, 64'hF1, 64'h0, 1'b0, 1);
        issue(1, 4'd5, 64'hFF, 64'h1, 64'h1, 1'b0, 1);
        issue(1, 4'd0, 64'hFF, 64'h1, 64'h0, 1'b0, 1);
        issue(1, 4'hF, 64'h12, 64'h34, 64'h0, 1'b1, 1);
        drain(50);
        issue(1, 4'd6, 64'h10, 64'hF1, 64'hF10, 1'b0, 8);
        drain(50);
        issue(1, 4'd6, 64'hB7, 64'h5D, 64'hB7 * 64'h5D, 1'b0, 8);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
